// File: rtl/ahb_gpio.sv
// ahb_gpio: AHB-Lite GPIO slave with zero wait states.
//   Parameters: WIDTH    number of pins (1..32)
//               DOUT_RST reset value of DATAOUT
//   Bus ports : HCLK, HRESETn (sync, active low), HSEL, HREADY, HWRITE, HTRANS,
//               HSIZE, HADDR, HWDATA -> HREADYOUT (always 1), HRDATA
//   Pin ports : GPIO_IN (async) -> GPIO_OUT (DATAOUT), GPIO_OE (DIR), IRQ (|INTSTAT)
//   Registers : 0x00 DATAOUT, 0x04 DATAIN, 0x08 DIR, 0x0C OUTSET, 0x10 OUTCLR,
//               0x14 INTEN, 0x18 INTSTAT (W1C), 0x1C reserved
module ahb_gpio #(
  parameter int unsigned      WIDTH    = 8,
  parameter logic [WIDTH-1:0] DOUT_RST = '0
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             HSEL,
  input  logic             HREADY,
  input  logic             HWRITE,
  input  logic [1:0]       HTRANS,
  input  logic [2:0]       HSIZE,
  input  logic [31:0]      HADDR,
  input  logic [31:0]      HWDATA,
  output logic             HREADYOUT,
  output logic [31:0]      HRDATA,
  input  logic [WIDTH-1:0] GPIO_IN,
  output logic [WIDTH-1:0] GPIO_OUT,
  output logic [WIDTH-1:0] GPIO_OE,
  output logic             IRQ
);

  localparam logic [2:0] REG_DATAOUT = 3'd0;
  localparam logic [2:0] REG_DATAIN  = 3'd1;
  localparam logic [2:0] REG_DIR     = 3'd2;
  localparam logic [2:0] REG_OUTSET  = 3'd3;
  localparam logic [2:0] REG_OUTCLR  = 3'd4;
  localparam logic [2:0] REG_INTEN   = 3'd5;
  localparam logic [2:0] REG_INTSTAT = 3'd6;

  // Pending data-phase state captured in the address phase
  logic             wr_q, wr_d;
  logic             rd_q, rd_d;
  logic [2:0]       addr_q, addr_d;
  logic [3:0]       strb_q, strb_d;

  // Architectural registers and input path
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] inten_q, inten_d;
  logic [WIDTH-1:0] intstat_q, intstat_d;
  logic [WIDTH-1:0] sync1_q, sync2_q, prev_q;

  logic             addr_act_c;
  logic [3:0]       strb_c;
  logic [31:0]      lane_mask_c;
  logic [WIDTH-1:0] wbits_c;
  logic [WIDTH-1:0] rise_c;
  logic [31:0]      rdata_c;
  logic             unused_c;

  assign addr_act_c = HSEL & HREADY & HTRANS[1];

  // Little-endian byte strobes; misaligned or oversized transfers get none
  always_comb begin
    strb_c = 4'b0000;
    unique case (HSIZE)
      3'd0: strb_c = 4'b0001 << HADDR[1:0];
      3'd1: if (!HADDR[0]) strb_c = HADDR[1] ? 4'b1100 : 4'b0011;
      3'd2: if (HADDR[1:0] == 2'b00) strb_c = 4'b1111;
      default: strb_c = 4'b0000;
    endcase
  end

  // Address-phase capture; held while another slave stalls HREADY
  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    addr_d = addr_q;
    strb_d = strb_q;
    if (HREADY) begin
      wr_d = addr_act_c & HWRITE;
      rd_d = addr_act_c & ~HWRITE;
      if (addr_act_c) begin
        addr_d = HADDR[4:2];
        strb_d = strb_c;
      end
    end
  end

  assign lane_mask_c = {{8{strb_q[3]}}, {8{strb_q[2]}}, {8{strb_q[1]}}, {8{strb_q[0]}}};
  assign wbits_c     = HWDATA[WIDTH-1:0] & lane_mask_c[WIDTH-1:0];
  assign rise_c      = sync2_q & ~prev_q;

  // Data-phase register update; a new edge beats a same-cycle W1C
  always_comb begin
    dout_d    = dout_q;
    dir_d     = dir_q;
    inten_d   = inten_q;
    intstat_d = intstat_q;
    if (wr_q) begin
      unique case (addr_q)
        REG_DATAOUT: dout_d    = (dout_q & ~lane_mask_c[WIDTH-1:0]) | wbits_c;
        REG_DIR:     dir_d     = (dir_q & ~lane_mask_c[WIDTH-1:0]) | wbits_c;
        REG_OUTSET:  dout_d    = dout_q | wbits_c;
        REG_OUTCLR:  dout_d    = dout_q & ~wbits_c;
        REG_INTEN:   inten_d   = (inten_q & ~lane_mask_c[WIDTH-1:0]) | wbits_c;
        REG_INTSTAT: intstat_d = intstat_q & ~wbits_c;
        default:     ;
      endcase
    end
    intstat_d = intstat_d | (rise_c & inten_q);
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      addr_q    <= '0;
      strb_q    <= '0;
      dout_q    <= DOUT_RST;
      dir_q     <= '0;
      inten_q   <= '0;
      intstat_q <= '0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      prev_q    <= '0;
    end else begin
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      addr_q    <= addr_d;
      strb_q    <= strb_d;
      dout_q    <= dout_d;
      dir_q     <= dir_d;
      inten_q   <= inten_d;
      intstat_q <= intstat_d;
      sync1_q   <= GPIO_IN;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
    end
  end

  // Read mux driven only by registered read state
  always_comb begin
    rdata_c = 32'h0;
    if (rd_q) begin
      unique case (addr_q)
        REG_DATAOUT: rdata_c = 32'(dout_q);
        REG_DATAIN:  rdata_c = 32'(sync2_q);
        REG_DIR:     rdata_c = 32'(dir_q);
        REG_INTEN:   rdata_c = 32'(inten_q);
        REG_INTSTAT: rdata_c = 32'(intstat_q);
        default:     rdata_c = 32'h0;
      endcase
    end
  end

  assign HRDATA    = rdata_c;
  assign HREADYOUT = 1'b1;
  assign GPIO_OUT  = dout_q;
  assign GPIO_OE   = dir_q;
  assign IRQ       = |intstat_q;

  assign unused_c = ^{HADDR[31:5], HWDATA, lane_mask_c, HTRANS[0]};

endmodule

// File: tb/tb_ahb_gpio.sv
// tb_ahb_gpio: directed table-driven bench for ahb_gpio (8-bit and 16-bit instances).
module tb_ahb_gpio;

  localparam int K_W   = 0;
  localparam int K_R   = 1;
  localparam int K_OUT = 2;
  localparam int K_OE  = 3;

  typedef struct {
    int          kind;
    bit          dut;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;

  logic        clk = 1'b0;
  logic        hresetn;
  logic        hsel8, hsel16, hready, hwrite;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [31:0] haddr, hwdata;
  logic        hreadyout8, hreadyout16;
  logic [31:0] hrdata8, hrdata16;
  logic [7:0]  gpio_in8, gpio_out8, gpio_oe8;
  logic [15:0] gpio_in16, gpio_out16, gpio_oe16;
  logic        irq8, irq16;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  ahb_gpio #(.WIDTH(8), .DOUT_RST(8'hA5)) u_dut8 (
    .HCLK(clk), .HRESETn(hresetn), .HSEL(hsel8), .HREADY(hready), .HWRITE(hwrite),
    .HTRANS(htrans), .HSIZE(hsize), .HADDR(haddr), .HWDATA(hwdata),
    .HREADYOUT(hreadyout8), .HRDATA(hrdata8),
    .GPIO_IN(gpio_in8), .GPIO_OUT(gpio_out8), .GPIO_OE(gpio_oe8), .IRQ(irq8)
  );

  ahb_gpio #(.WIDTH(16), .DOUT_RST(16'h0000)) u_dut16 (
    .HCLK(clk), .HRESETn(hresetn), .HSEL(hsel16), .HREADY(hready), .HWRITE(hwrite),
    .HTRANS(htrans), .HSIZE(hsize), .HADDR(haddr), .HWDATA(hwdata),
    .HREADYOUT(hreadyout16), .HRDATA(hrdata16),
    .GPIO_IN(gpio_in16), .GPIO_OUT(gpio_out16), .GPIO_OE(gpio_oe16), .IRQ(irq16)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else n_pass++;
  endtask

  task automatic addr_phase(input bit dut, input logic wr, input logic [31:0] a,
                            input logic [2:0] sz);
    hsel8  = (dut == 1'b0);
    hsel16 = dut;
    htrans = 2'b10;
    hwrite = wr;
    haddr  = a;
    hsize  = sz;
  endtask

  task automatic idle_addr();
    hsel8  = 1'b0;
    hsel16 = 1'b0;
    htrans = 2'b00;
    hwrite = 1'b0;
  endtask

  task automatic bus_write(input bit dut, input logic [31:0] a, input logic [2:0] sz,
                           input logic [31:0] d);
    addr_phase(dut, 1'b1, a, sz);
    @(posedge clk); #1;
    idle_addr();
    hwdata = d;
    @(posedge clk); #1;
  endtask

  task automatic bus_read(input bit dut, input logic [31:0] a, output logic [31:0] d);
    addr_phase(dut, 1'b0, a, 3'd2);
    @(posedge clk); #1;
    idle_addr();
    d = dut ? hrdata16 : hrdata8;
    @(posedge clk); #1;
  endtask

  function automatic vec_t v(input int k, input bit d, input logic [31:0] a,
                             input logic [2:0] s, input logic [31:0] wd,
                             input logic [31:0] e, input string n);
    vec_t r;
    r.kind = k; r.dut = d; r.addr = a; r.size = s; r.wdata = wd; r.exp = e; r.name = n;
    return r;
  endfunction

  initial begin
    vec_t        vecs[$];
    logic [31:0] rd;
    logic        irq_seen [1:3];

    vecs.push_back(v(K_R,   0, 32'h00, 3'd2, 32'h0,         32'h0000_00A5, "rst_dataout_rd"));
    vecs.push_back(v(K_W,   0, 32'h08, 3'd2, 32'hFFFF_00F0, 32'h0,         "w_dir"));
    vecs.push_back(v(K_R,   0, 32'h08, 3'd2, 32'h0,         32'h0000_00F0, "dir_rd"));
    vecs.push_back(v(K_OE,  0, 32'h0,  3'd0, 32'h0,         32'h0000_00F0, "gpio_oe"));
    vecs.push_back(v(K_OUT, 0, 32'h0,  3'd0, 32'h0,         32'h0000_00A5, "out_after_dir"));
    vecs.push_back(v(K_W,   0, 32'h00, 3'd2, 32'h0000_000F, 32'h0,         "w_dout"));
    vecs.push_back(v(K_W,   0, 32'h01, 3'd0, 32'h0000_AA00, 32'h0,         "w_byte_lane1"));
    vecs.push_back(v(K_R,   0, 32'h00, 3'd2, 32'h0,         32'h0000_000F, "byte_above_width"));
    vecs.push_back(v(K_W,   0, 32'h0C, 3'd2, 32'h0000_0030, 32'h0,         "w_outset"));
    vecs.push_back(v(K_OUT, 0, 32'h0,  3'd0, 32'h0,         32'h0000_003F, "out_after_set"));
    vecs.push_back(v(K_R,   0, 32'h0C, 3'd2, 32'h0,         32'h0,         "outset_reads0"));
    vecs.push_back(v(K_W,   0, 32'h10, 3'd2, 32'h0000_0003, 32'h0,         "w_outclr"));
    vecs.push_back(v(K_R,   0, 32'h00, 3'd2, 32'h0,         32'h0000_003C, "dout_after_clr"));
    vecs.push_back(v(K_R,   0, 32'h10, 3'd2, 32'h0,         32'h0,         "outclr_reads0"));
    vecs.push_back(v(K_W,   0, 32'h01, 3'd1, 32'hFFFF_FFFF, 32'h0,         "w_hw_unaligned"));
    vecs.push_back(v(K_R,   0, 32'h00, 3'd2, 32'h0,         32'h0000_003C, "hw_unaligned_ign"));
    vecs.push_back(v(K_W,   0, 32'h00, 3'd3, 32'h0,         32'h0,         "w_size3"));
    vecs.push_back(v(K_R,   0, 32'h00, 3'd2, 32'h0,         32'h0000_003C, "size3_ign"));
    vecs.push_back(v(K_W,   0, 32'h00, 3'd1, 32'hFFFF_0055, 32'h0,         "w_hw_lane0"));
    vecs.push_back(v(K_R,   0, 32'h00, 3'd2, 32'h0,         32'h0000_0055, "hw_lane0"));
    vecs.push_back(v(K_W,   0, 32'h00, 3'd0, 32'h0000_00AA, 32'h0,         "w_byte_lane0"));
    vecs.push_back(v(K_OUT, 0, 32'h0,  3'd0, 32'h0,         32'h0000_00AA, "byte_lane0"));
    vecs.push_back(v(K_W,   0, 32'h14, 3'd2, 32'h0000_00FF, 32'h0,         "w_inten_ff"));
    vecs.push_back(v(K_R,   0, 32'h14, 3'd2, 32'h0,         32'h0000_00FF, "inten_rd"));
    vecs.push_back(v(K_W,   0, 32'h14, 3'd2, 32'h0000_0001, 32'h0,         "w_inten_01"));
    vecs.push_back(v(K_W,   0, 32'h1C, 3'd2, 32'hFFFF_FFFF, 32'h0,         "w_reserved"));
    vecs.push_back(v(K_R,   0, 32'h1C, 3'd2, 32'h0,         32'h0,         "reserved_reads0"));
    vecs.push_back(v(K_R,   0, 32'h18, 3'd2, 32'h0,         32'h0,         "intstat_idle"));
    vecs.push_back(v(K_W,   1, 32'h00, 3'd2, 32'h0000_1234, 32'h0,         "w16_dout"));
    vecs.push_back(v(K_W,   1, 32'h01, 3'd0, 32'h0000_AA00, 32'h0,         "w16_byte1"));
    vecs.push_back(v(K_R,   1, 32'h00, 3'd2, 32'h0,         32'h0000_AA34, "w16_byte1_rd"));
    vecs.push_back(v(K_W,   1, 32'h01, 3'd1, 32'hFFFF_FFFF, 32'h0,         "w16_hw_unal"));
    vecs.push_back(v(K_R,   1, 32'h00, 3'd2, 32'h0,         32'h0000_AA34, "w16_hw_unal_rd"));
    vecs.push_back(v(K_W,   1, 32'h02, 3'd1, 32'hBEEF_0000, 32'h0,         "w16_hw_upper"));
    vecs.push_back(v(K_OUT, 1, 32'h0,  3'd0, 32'h0,         32'h0000_AA34, "w16_hw_upper_ign"));
    vecs.push_back(v(K_W,   1, 32'h08, 3'd2, 32'hFFFF_FFFF, 32'h0,         "w16_dir"));
    vecs.push_back(v(K_OE,  1, 32'h0,  3'd0, 32'h0,         32'h0000_FFFF, "w16_oe"));

    hresetn = 1'b0; hready = 1'b1; hwdata = 32'h0; haddr = 32'h0; hsize = 3'd0;
    gpio_in8 = 8'h00; gpio_in16 = 16'h0000;
    idle_addr();
    repeat (2) @(posedge clk);
    #1 hresetn = 1'b1;

    check("rst_gpio_out", 32'(gpio_out8), 32'h0000_00A5);
    check("rst_gpio_oe",  32'(gpio_oe8),  32'h0);
    check("rst_irq",      32'(irq8),      32'h0);
    check("rst_hrdata",   hrdata8,        32'h0);
    check("hreadyout",    32'(hreadyout8), 32'h1);

    foreach (vecs[i]) begin
      case (vecs[i].kind)
        K_W: bus_write(vecs[i].dut, vecs[i].addr, vecs[i].size, vecs[i].wdata);
        K_R: begin
          bus_read(vecs[i].dut, vecs[i].addr, rd);
          check(vecs[i].name, rd, vecs[i].exp);
        end
        K_OUT: check(vecs[i].name, vecs[i].dut ? 32'(gpio_out16) : 32'(gpio_out8), vecs[i].exp);
        default: check(vecs[i].name, vecs[i].dut ? 32'(gpio_oe16) : 32'(gpio_oe8), vecs[i].exp);
      endcase
    end

    // OUTSET then OUTCLR back-to-back: each lands one cycle apart
    bus_write(1'b0, 32'h00, 3'd2, 32'h0000_000F);
    addr_phase(1'b0, 1'b1, 32'h0C, 3'd2);
    @(posedge clk); #1;
    hwdata = 32'h0000_0030;
    addr_phase(1'b0, 1'b1, 32'h10, 3'd2);
    @(posedge clk); #1;
    check("b2b_set", 32'(gpio_out8), 32'h0000_003F);
    hwdata = 32'h0000_0003;
    idle_addr();
    @(posedge clk); #1;
    check("b2b_clr", 32'(gpio_out8), 32'h0000_003C);

    // Read pipelined right behind a write sees the new value
    addr_phase(1'b0, 1'b1, 32'h00, 3'd2);
    @(posedge clk); #1;
    hwdata = 32'h0000_0077;
    addr_phase(1'b0, 1'b0, 32'h00, 3'd2);
    @(posedge clk); #1;
    idle_addr();
    check("raw_pipelined", hrdata8, 32'h0000_0077);
    @(posedge clk); #1;

    // Rising edge on pin 0 with INTEN=1: IRQ exactly three cycles later
    gpio_in8[0] = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      irq_seen[c] = irq8;
    end
    check("irq_cyc1", 32'(irq_seen[1]), 32'h0);
    check("irq_cyc2", 32'(irq_seen[2]), 32'h0);
    check("irq_cyc3", 32'(irq_seen[3]), 32'h1);
    bus_read(1'b0, 32'h18, rd);
    check("intstat_set", rd, 32'h0000_0001);
    bus_write(1'b0, 32'h18, 3'd2, 32'h0000_0001);
    check("w1c_clears", 32'(irq8), 32'h0);

    // W1C landing on the same edge as a new rising edge: set wins
    gpio_in8[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1 gpio_in8[0] = 1'b1;
    @(posedge clk); #1;
    addr_phase(1'b0, 1'b1, 32'h18, 3'd2);
    @(posedge clk); #1;
    hwdata = 32'h0000_0001;
    idle_addr();
    @(posedge clk); #1;
    check("w1c_vs_edge_irq", 32'(irq8), 32'h1);
    bus_read(1'b0, 32'h18, rd);
    check("w1c_vs_edge_stat", rd, 32'h0000_0001);

    bus_write(1'b0, 32'h14, 3'd2, 32'h0);
    check("inten_clr_keeps", 32'(irq8), 32'h1);
    bus_write(1'b0, 32'h18, 3'd2, 32'h0000_00FF);
    check("w1c_all", 32'(irq8), 32'h0);

    // Edge on a pin with interrupts disabled
    gpio_in8[1] = 1'b1;
    repeat (5) @(posedge clk);
    #1 check("masked_edge", 32'(irq8), 32'h0);
    bus_read(1'b0, 32'h04, rd);
    check("datain", rd, 32'h0000_0003);

    // Reset during a write's data phase discards the write
    addr_phase(1'b0, 1'b1, 32'h00, 3'd2);
    @(posedge clk); #1;
    idle_addr();
    hwdata  = 32'h0000_00FF;
    hresetn = 1'b0;
    @(posedge clk); #1;
    hresetn = 1'b1;
    check("rst_wr_out", 32'(gpio_out8), 32'h0000_00A5);
    check("rst_wr_oe",  32'(gpio_oe8),  32'h0);
    check("rst_wr_irq", 32'(irq8),      32'h0);
    bus_read(1'b0, 32'h1C, rd);
    check("rst_rd_1c", rd, 32'h0);

    // IDLE transfer with HSEL high is ignored
    hsel8 = 1'b1; htrans = 2'b00; hwrite = 1'b1; haddr = 32'h00; hsize = 3'd2;
    @(posedge clk); #1;
    idle_addr();
    hwdata = 32'h0000_0000;
    @(posedge clk); #1;
    check("idle_write_ign", 32'(gpio_out8), 32'h0000_00A5);

    // Address phase while HREADY is low is not captured
    addr_phase(1'b0, 1'b1, 32'h08, 3'd2);
    hready = 1'b0;
    @(posedge clk); #1;
    hready = 1'b1;
    idle_addr();
    hwdata = 32'h0000_00FF;
    @(posedge clk); #1;
    check("hready_low_ign", 32'(gpio_oe8), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ahb_gpio.md
Name: ahb_gpio

Overview:
Parametrised AHB-Lite GPIO slave; successor to the fixed 8-bit output-only LED port. Provides WIDTH bidirectional pins with per-bit direction, atomic set/clear, byte-lane writes, a 2-flop input synchroniser and rising-edge interrupts. Sits on the system AHB-Lite bus behind the address decoder, zero wait state.

Parameters:
WIDTH, 8, number of GPIO pins (1..32); register bits above WIDTH-1 read 0, writes ignored
DOUT_RST, 0, reset value of DATAOUT[WIDTH-1:0]

Ports:
HCLK  in  1  bus clock; all logic on rising edge
HRESETn  in  1  synchronous active-low reset, sampled on HCLK rising edge
HSEL  in  1  slave select from decoder
HREADY  in  1  bus ready; address phase accepted only when high
HWRITE  in  1  1 = write transfer
HTRANS  in  2  transfer type; HTRANS[1]=1 (NONSEQ/SEQ) is active
HSIZE  in  3  0 byte, 1 halfword, 2 word
HADDR  in  32  address; [4:2] register select, [1:0] byte offset
HWDATA  in  32  write data, data phase
HREADYOUT  out  1  constant 1
HRDATA  out  32  read data, data phase
GPIO_IN  in  WIDTH  asynchronous pin inputs
GPIO_OUT  out  WIDTH  = DATAOUT
GPIO_OE  out  WIDTH  = DIR (1 = drive)
IRQ  out  1  OR of INTSTAT

Behaviour:
- Address phase: when HSEL & HREADY & HTRANS[1], register write flag, read flag, HADDR[4:2] and byte strobes; else clear both flags (when HREADY). Data-phase action uses registered values only.
- Byte strobes (little-endian): HSIZE=0 -> lane HADDR[1:0]; HSIZE=1 -> lanes {1,0} or {3,2} by HADDR[1]; HSIZE=2 -> all four. Unaligned or HSIZE>2 -> no strobes (write ignored).
- Register map (offset): 0x00 DATAOUT RW; 0x04 DATAIN RO; 0x08 DIR RW; 0x0C OUTSET WO (write 1 sets DATAOUT bit); 0x10 OUTCLR WO (write 1 clears); 0x14 INTEN RW; 0x18 INTSTAT RW1C. 0x1C reads 0, writes ignored. WO registers read 0.
- Writes take effect at end of data phase (HWDATA sampled there); a read in the next cycle returns the updated value.
- HRDATA: combinational from registered read address; 0 when no read is pending. Zero-extend above WIDTH.
- Input path: GPIO_IN -> sync1 -> sync2 (DATAIN); prev = sync2 delayed one cycle. Rising edge = sync2 & ~prev. Pin-to-DATAIN latency 2 cycles; edge to INTSTAT set 3 cycles.
- INTSTAT[i] sets on rising edge when INTEN[i]=1. Same-cycle edge and W1C on the same bit -> set wins. Clearing INTEN does not clear INTSTAT.
- IRQ registered-free: IRQ = |INTSTAT.
- Reset (HRESETn=0 at clock edge): DATAOUT=DOUT_RST, DIR=0, INTEN=0, INTSTAT=0, sync1/sync2/prev=0, pending flags cleared. Outputs: GPIO_OUT=DOUT_RST, GPIO_OE=0, IRQ=0, HRDATA=0, HREADYOUT=1. A write whose data phase coincides with reset is discarded. First cycle after reset cannot raise INTSTAT from a pin already high until it has propagated and then risen (prev tracks sync2 from 0, so a high pin produces one edge).
- Back-to-back transfers with HREADY held high fully pipelined; HREADY low from another slave stalls address capture (registered state held).

Test Plan:
- Reset with WIDTH=8, DOUT_RST=8'hA5 -> GPIO_OUT=8'hA5, GPIO_OE=0, IRQ=0; read 0x00 returns 32'h0000_00A5.
- Word write 0x08=32'hFFFF_00F0, then read -> GPIO_OE=8'hF0, HRDATA=32'h0000_00F0.
- DATAOUT=8'h0F; write OUTSET=8'h30, then OUTCLR=8'h03 back-to-back -> GPIO_OUT 8'h3F then 8'h3C, one cycle apart.
- Byte write HSIZE=0, HADDR=0x01, HWDATA=32'h0000_AA00 with WIDTH=16, DATAOUT=16'h1234 -> DATAOUT=16'hAA34; halfword to 0x01 -> unchanged.
- INTEN=8'h01; drive GPIO_IN[0] 0->1 -> INTSTAT[0]=1 and IRQ=1 exactly 3 cycles later; write 0x18=1 -> IRQ=0; repeat with W1C coincident with edge -> INTSTAT stays 1.
- Start write to 0x00 (data 8'hFF), assert HRESETn=0 in its data phase -> DATAOUT=DOUT_RST; read of 0x1C returns 0; HTRANS=IDLE write does not change any register.
